// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed driver for a 4-digit seven-segment display. Four 7-bit
// active-low segment patterns are captured into a double buffer (pending /
// active) and scanned onto one shared segment bus with one-hot active-low
// digit enables. Every digit slot starts with a blanking interval to suppress
// ghosting, and new patterns only reach the display at frame boundaries so a
// frame never shows a mix of old and new digits.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : blank cycles at the start of each slot (1 .. REFRESH_DIV-1)
//
// Ports
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   seg1_in    : ones-digit pattern (active-low segments)
//   seg2_in    : tens-digit pattern
//   seg3_in    : hundreds-digit pattern
//   seg4_in    : sign-digit pattern
//   load       : one-cycle strobe capturing seg1_in..seg4_in
//   enable     : level; scanning runs while high
//   seg_out    : shared segment bus, active-low
//   digit_en   : digit enables, active-low, bit 0 = seg1 .. bit 3 = seg4
//   frame_done : one-cycle pulse on the last drive cycle of digit 3
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [6:0] seg1_in,
   input  logic [6:0] seg2_in,
   input  logic [6:0] seg3_in,
   input  logic [6:0] seg4_in,
   input  logic       load,
   input  logic       enable,
   output logic [6:0] seg_out,
   output logic [3:0] digit_en,
   output logic       frame_done
);

   localparam int                 CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_PRELAST = CNT_W'(REFRESH_DIV - 2);
   localparam logic [CNT_W-1:0]   BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [6:0]         SEG_BLANK   = 7'h7F;
   localparam logic [3:0]         DIG_OFF     = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_dig;
   logic [6:0]       r_active  [4];
   logic [6:0]       r_pending [4];
   logic             r_pending_valid;

   logic [3:0]       w_dig_en_n;
   logic             w_boundary;

   assign w_dig_en_n = ~(4'b0001 << r_dig);

   // Last drive cycle of digit 3 while still enabled: the only point where
   // the active buffer may change during scanning.
   assign w_boundary = enable && (r_state == DRIVE) && (r_dig == 2'd3) &&
                       (r_cnt == CNT_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_dig           <= 2'd0;
         seg_out         <= SEG_BLANK;
         digit_en        <= DIG_OFF;
         frame_done      <= 1'b0;
         r_pending_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_active[i]  <= SEG_BLANK;
            r_pending[i] <= SEG_BLANK;
         end
      end else begin
         // Outputs are blank unless the state entered at this edge drives.
         seg_out    <= SEG_BLANK;
         digit_en   <= DIG_OFF;
         frame_done <= 1'b0;

         if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dig   <= 2'd0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= BLANK;
                  r_cnt   <= '0;
                  r_dig   <= 2'd0;
               end
               BLANK: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == BLANK_LAST) begin
                     r_state  <= DRIVE;
                     digit_en <= w_dig_en_n;
                     seg_out  <= r_active[r_dig];
                     // With a single drive cycle the entry cycle is the last.
                     if (r_dig == 2'd3 && BLANK_CYCLES == REFRESH_DIV - 1)
                        frame_done <= 1'b1;
                  end
               end
               DRIVE: begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= BLANK;
                     r_cnt   <= '0;
                     r_dig   <= r_dig + 1'b1;
                  end else begin
                     r_cnt    <= r_cnt + 1'b1;
                     digit_en <= w_dig_en_n;
                     seg_out  <= r_active[r_dig];
                     if (r_dig == 2'd3 && r_cnt == CNT_PRELAST)
                        frame_done <= 1'b1;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_dig   <= 2'd0;
               end
            endcase
         end

         // Double-buffer update. While idle nothing is on screen, so data
         // goes straight to active and any older pending data is dropped.
         if (load && r_state == IDLE) begin
            r_active[0]     <= seg1_in;
            r_active[1]     <= seg2_in;
            r_active[2]     <= seg3_in;
            r_active[3]     <= seg4_in;
            r_pending_valid <= 1'b0;
         end else if (w_boundary) begin
            if (load) begin
               r_active[0] <= seg1_in;
               r_active[1] <= seg2_in;
               r_active[2] <= seg3_in;
               r_active[3] <= seg4_in;
            end else if (r_pending_valid) begin
               for (int i = 0; i < 4; i++)
                  r_active[i] <= r_pending[i];
            end
            r_pending_valid <= 1'b0;
         end else if (load) begin
            r_pending[0]    <= seg1_in;
            r_pending[1]    <= seg2_in;
            r_pending[2]    <= seg3_in;
            r_pending[3]    <= seg4_in;
            r_pending_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Bench for seven_segment_scanner with REFRESH_DIV=8, BLANK_CYCLES=2. A
// frame-position model predicts the outputs every cycle; directed literal
// checks pin the model at hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

   localparam int RD    = 8;
   localparam int BL    = 2;
   localparam int FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg1_in = 7'h7F;
   logic [6:0] seg2_in = 7'h7F;
   logic [6:0] seg3_in = 7'h7F;
   logic [6:0] seg4_in = 7'h7F;
   logic       load = 1'b0;
   logic       enable = 1'b0;
   logic [6:0] seg_out;
   logic [3:0] digit_en;
   logic       frame_done;

   int n_checks = 0;
   int n_errors = 0;

   seven_segment_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
      .clock      (clk),
      .reset_n    (rst_n),
      .seg1_in    (seg1_in),
      .seg2_in    (seg2_in),
      .seg3_in    (seg3_in),
      .seg4_in    (seg4_in),
      .load       (load),
      .enable     (enable),
      .seg_out    (seg_out),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Model: m_run says a scan is in progress, m_pos is the position of the
   // current cycle inside the 4*RD-cycle frame.
   logic       m_run = 1'b0;
   int         m_pos = 0;
   logic       m_pv  = 1'b0;
   logic [6:0] m_act  [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
   logic [6:0] m_pend [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  <= 1'b0;
         m_pos  <= 0;
         m_pv   <= 1'b0;
         m_act  <= '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
         m_pend <= '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
      end else begin
         if (load && !m_run) begin
            m_act <= '{seg1_in, seg2_in, seg3_in, seg4_in};
            m_pv  <= 1'b0;
         end else if (enable && m_run && m_pos == FRAME - 1) begin
            if (load)      m_act <= '{seg1_in, seg2_in, seg3_in, seg4_in};
            else if (m_pv) m_act <= m_pend;
            m_pv <= 1'b0;
         end else if (load) begin
            m_pend <= '{seg1_in, seg2_in, seg3_in, seg4_in};
            m_pv   <= 1'b1;
         end

         if (!enable) begin
            m_run <= 1'b0;
         end else if (!m_run) begin
            m_run <= 1'b1;
            m_pos <= 0;
         end else begin
            m_pos <= (m_pos + 1) % FRAME;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      logic [6:0] e_seg;
      logic [3:0] e_dig;
      logic       e_fd;
      logic [3:0] one;
      int         slot;
      int         off;
      e_seg = 7'h7F;
      e_dig = 4'hF;
      e_fd  = 1'b0;
      one   = 4'b0001;
      if (m_run) begin
         slot = m_pos / RD;
         off  = m_pos % RD;
         if (off >= BL) begin
            e_dig = ~(one << slot);
            e_seg = m_act[slot];
         end
         e_fd = (m_pos == FRAME - 1);
      end
      chk("model_seg_out", {25'd0, seg_out}, {25'd0, e_seg});
      chk("model_digit_en", {28'd0, digit_en}, {28'd0, e_dig});
      chk("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(input string name, input logic [3:0] dig, input logic [6:0] seg, input logic fd);
      chk({name, "_digit_en"}, {28'd0, digit_en}, {28'd0, dig});
      chk({name, "_seg_out"}, {25'd0, seg_out}, {25'd0, seg});
      chk({name, "_frame_done"}, {31'd0, frame_done}, {31'd0, fd});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and idle behaviour
      tick(3);
      lit("reset_hold", 4'hF, 7'h7F, 1'b0);
      rst_n = 1'b1;
      tick(3);
      lit("idle_disabled", 4'hF, 7'h7F, 1'b0);

      // Load while idle, then scan; enable sampled at edge t
      seg1_in = 7'h40; seg2_in = 7'h79; seg3_in = 7'h24; seg4_in = 7'h7F;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      enable = 1'b1;
      tick(1);                                  // cycle t+1
      lit("t1_blank", 4'hF, 7'h7F, 1'b0);
      tick(1);                                  // t+2
      lit("t2_blank", 4'hF, 7'h7F, 1'b0);
      tick(1);                                  // t+3
      lit("t3_dig0", 4'b1110, 7'h40, 1'b0);
      tick(5);                                  // t+8
      lit("t8_dig0", 4'b1110, 7'h40, 1'b0);
      tick(1);                                  // t+9
      lit("t9_blank", 4'hF, 7'h7F, 1'b0);
      tick(2);                                  // t+11
      lit("t11_dig1", 4'b1101, 7'h79, 1'b0);
      tick(5);                                  // t+16
      lit("t16_dig1", 4'b1101, 7'h79, 1'b0);
      tick(3);                                  // t+19
      lit("t19_dig2", 4'b1011, 7'h24, 1'b0);
      tick(12);                                 // t+31
      lit("t31_dig3", 4'b0111, 7'h7F, 1'b0);
      tick(1);                                  // t+32
      lit("t32_boundary", 4'b0111, 7'h7F, 1'b1);
      tick(1);                                  // t+33, frame 2 pos 0
      lit("t33_blank", 4'hF, 7'h7F, 1'b0);

      // Tear-free update: load mid-frame at pos 5
      tick(5);                                  // t+38
      seg1_in = 7'h30;
      load = 1'b1;
      tick(1);                                  // t+39
      load = 1'b0;
      lit("tear_old_held", 4'b1110, 7'h40, 1'b0);
      tick(28);                                 // t+67, frame 3 pos 2
      lit("tear_new_shown", 4'b1110, 7'h30, 1'b0);

      // Load coincident with frame_done
      tick(29);                                 // t+96
      lit("bnd_cycle", 4'b0111, 7'h7F, 1'b1);
      seg1_in = 7'h12; seg2_in = 7'h02;
      load = 1'b1;
      tick(1);                                  // t+97
      load = 1'b0;
      chk("bnd_pending_valid", {31'd0, dut.r_pending_valid}, 32'd0);
      tick(2);                                  // t+99
      lit("bnd_dig0", 4'b1110, 7'h12, 1'b0);
      tick(8);                                  // t+107
      lit("bnd_dig1", 4'b1101, 7'h02, 1'b0);

      // Back-to-back loads: A then B in one frame
      seg1_in = 7'h19;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      tick(3);
      seg1_in = 7'h78;
      load = 1'b1;
      tick(1);                                  // t+112
      load = 1'b0;
      tick(19);                                 // t+131
      lit("b2b_last_wins", 4'b1110, 7'h78, 1'b0);

      // Enable drop during digit 2 drive (frame 5 pos 20)
      tick(18);                                 // t+149
      lit("drop_dig2", 4'b1011, 7'h24, 1'b0);
      enable = 1'b0;
      tick(1);
      lit("drop_blank", 4'hF, 7'h7F, 1'b0);
      tick(3);
      lit("drop_idle", 4'hF, 7'h7F, 1'b0);
      enable = 1'b1;
      tick(1);                                  // u+1
      lit("reen_blank1", 4'hF, 7'h7F, 1'b0);
      tick(1);                                  // u+2
      lit("reen_blank2", 4'hF, 7'h7F, 1'b0);
      tick(1);                                  // u+3
      lit("reen_dig0", 4'b1110, 7'h78, 1'b0);

      // Asynchronous reset mid-drive
      #1;
      rst_n = 1'b0;
      #1;
      lit("async_reset", 4'hF, 7'h7F, 1'b0);
      enable = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      lit("post_reset_idle", 4'hF, 7'h7F, 1'b0);
      enable = 1'b1;
      tick(3);
      lit("post_reset_active", 4'b1110, 7'h7F, 1'b0);
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
